stopwatch_counter: RTL and testbench

Stopwatch time-keeping stage, directly downstream of the clock-source selector that drives `clkOut` with either the 1 Hz or 2 Hz enable depending on ADJ. It detects rising edges of that selected tick in the `clk` domain and keeps a BCD MM:SS count. In normal mode the count advances; in adjust mode it advances only the field picked by SEL. The four BCD digits feed the seven-segment scan/blink logic.

---
 rtl/stopwatch_counter.sv | 72 +++++++
 tb/tb_stopwatch_counter.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/stopwatch_counter.sv
// BCD MM:SS stopwatch advanced by rising edges of the selected timebase level.
// Normal mode carries through all four digits; adjust mode steps one 00..59 field.
module stopwatch_counter #(
  parameter bit RESET_RUNNING = 1'b0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tick,
  input  logic       ADJ,
  input  logic       SEL,
  input  logic       pause,
  output logic [3:0] min_tens,
  output logic [3:0] min_ones,
  output logic [3:0] sec_tens,
  output logic [3:0] sec_ones,
  output logic       running,
  output logic       wrap
);

  typedef enum logic {PAUSE = 1'b0, RUN = 1'b1} run_state_t;

  run_state_t state;
  logic       tick_q;
  logic       tick_edge;
  logic       norm_step;
  logic       sec_full;
  logic       min_full;
  logic       adv_sec;
  logic       adv_min;

  // One 00..59 BCD field step; out-of-range digits fold back to 0.
  function automatic logic [7:0] inc_60(input logic [3:0] tens, input logic [3:0] ones);
    logic [3:0] t;
    logic [3:0] o;
    if (ones >= 4'd9) begin
      o = 4'd0;
      t = (tens >= 4'd5) ? 4'd0 : tens + 4'd1;
    end else begin
      o = ones + 4'd1;
      t = (tens > 4'd5) ? 4'd0 : tens;
    end
    return {t, o};
  endfunction

  assign tick_edge = tick & ~tick_q;
  assign sec_full  = (sec_tens == 4'd5) && (sec_ones == 4'd9);
  assign min_full  = (min_tens == 4'd5) && (min_ones == 4'd9);
  // Run decision uses the pre-toggle state, so a coincident pause acts after the edge.
  assign norm_step = tick_edge & ~ADJ & (state == RUN);
  assign adv_sec   = norm_step | (tick_edge & ADJ & SEL);
  assign adv_min   = (norm_step & sec_full) | (tick_edge & ADJ & ~SEL);
  assign running   = (state == RUN);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= RESET_RUNNING ? RUN : PAUSE;
      tick_q   <= 1'b0;
      wrap     <= 1'b0;
      min_tens <= 4'd0;
      min_ones <= 4'd0;
      sec_tens <= 4'd0;
      sec_ones <= 4'd0;
    end else begin
      tick_q <= tick;
      wrap   <= norm_step & sec_full & min_full;
      if (pause) state <= (state == RUN) ? PAUSE : RUN;
      if (adv_sec) {sec_tens, sec_ones} <= inc_60(sec_tens, sec_ones);
      if (adv_min) {min_tens, min_ones} <= inc_60(min_tens, min_ones);
    end
  end

endmodule

// File: tb/tb_stopwatch_counter.sv
// Directed bench for stopwatch_counter: run/pause, carries, adjust fields,
// wrap pulse width and asynchronous reset.
module tb_stopwatch_counter;

  logic       clk;
  logic       rst_n;
  logic       tick;
  logic       ADJ;
  logic       SEL;
  logic       pause;
  logic [3:0] min_tens;
  logic [3:0] min_ones;
  logic [3:0] sec_tens;
  logic [3:0] sec_ones;
  logic       running;
  logic       wrap;

  int n_checks = 0;
  int n_pass   = 0;
  int wrap_cnt = 0;
  int wrap_base;

  stopwatch_counter #(.RESET_RUNNING(1'b0)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .tick     (tick),
    .ADJ      (ADJ),
    .SEL      (SEL),
    .pause    (pause),
    .min_tens (min_tens),
    .min_ones (min_ones),
    .sec_tens (sec_tens),
    .sec_ones (sec_ones),
    .running  (running),
    .wrap     (wrap)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(negedge clk) if (wrap) wrap_cnt++;

  function automatic logic [15:0] disp();
    return {min_tens, min_ones, sec_tens, sec_ones};
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // driver tasks
  task automatic tick_pulses(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk) tick = 1'b1;
      @(negedge clk) tick = 1'b0;
    end
  endtask

  task automatic pause_pulse();
    @(negedge clk) pause = 1'b1;
    @(negedge clk) pause = 1'b0;
  endtask

  task automatic pause_with_tick();
    @(negedge clk) begin tick = 1'b1; pause = 1'b1; end
    @(negedge clk) begin tick = 1'b0; pause = 1'b0; end
  endtask

  task automatic adjust(input logic sel, input int n);
    @(negedge clk) begin ADJ = 1'b1; SEL = sel; end
    tick_pulses(n);
  endtask

  initial begin
    rst_n = 1'b0; tick = 1'b0; ADJ = 1'b0; SEL = 1'b0; pause = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_digits", disp(), 16'h0000);
    check("reset_running", running, 0);
    check("reset_wrap", wrap, 0);
    rst_n = 1'b1;

    // paused after reset: ticks ignored
    tick_pulses(5);
    check("paused_digits", disp(), 16'h0000);
    check("paused_running", running, 0);

    pause_pulse();
    check("run_after_pause", running, 1);
    wrap_base = wrap_cnt;
    tick_pulses(61);
    check("run_61", disp(), 16'h0101);
    check("run_61_running", running, 1);
    check("run_61_no_wrap", wrap_cnt - wrap_base, 0);

    // adjust fields: seconds then minutes, each wrapping at 59
    wrap_base = wrap_cnt;
    adjust(1'b1, 57);
    adjust(1'b0, 59);
    check("adj_preset_0058", disp(), 16'h0058);
    adjust(1'b1, 3);
    check("adj_sec_wrap", disp(), 16'h0001);
    adjust(1'b0, 58);
    check("adj_min_58", disp(), 16'h5801);
    adjust(1'b0, 3);
    check("adj_min_wrap", disp(), 16'h0101);
    check("adj_no_wrap", wrap_cnt - wrap_base, 0);

    // full rollover 59:59 -> 00:00
    adjust(1'b0, 58);
    adjust(1'b1, 58);
    check("preload_5959", disp(), 16'h5959);
    @(negedge clk) ADJ = 1'b0;
    wrap_base = wrap_cnt;
    @(negedge clk) tick = 1'b1;
    @(negedge clk) tick = 1'b0;
    check("wrap_digits", disp(), 16'h0000);
    check("wrap_high", wrap, 1);
    @(negedge clk);
    check("wrap_low_after", wrap, 0);
    check("wrap_one_cycle", wrap_cnt - wrap_base, 1);

    // pause coincident with a tick edge
    tick_pulses(10);
    check("run_0010", disp(), 16'h0010);
    pause_with_tick();
    check("run_pause_edge_digits", disp(), 16'h0011);
    check("run_pause_edge_state", running, 0);
    tick_pulses(1);
    check("paused_hold", disp(), 16'h0011);
    pause_with_tick();
    check("pause_pause_edge_digits", disp(), 16'h0011);
    check("pause_pause_edge_state", running, 1);

    // async reset between edges, then tick held high through release
    adjust(1'b0, 12);
    adjust(1'b1, 23);
    check("preset_1234", disp(), 16'h1234);
    @(posedge clk);
    #2 rst_n = 1'b0;
    tick = 1'b1;
    #1;
    check("async_reset_digits", disp(), 16'h0000);
    check("async_reset_running", running, 0);
    @(negedge clk) rst_n = 1'b1;
    repeat (4) @(negedge clk);
    check("held_tick_one_inc", disp(), 16'h0001);
    tick = 1'b0;
    ADJ = 1'b0;
    repeat (2) @(negedge clk);
    check("held_tick_final", disp(), 16'h0001);

    // final report
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
